reservation_station: RTL and testbench
======================================

# reservation_station

Out-of-order issue buffer for non-memory instructions. It sits between the reorder buffer and the ALU. Each cycle it accepts at most one dispatched instruction from the ROB and holds it until both source operands are available, capturing operand values from ROB commit broadcasts. It then issues one ready instruction per cycle to the ALU and back-pressures the instruction queue and ROB when full.

## Interface
- RsLength, default 7: index of the last entry; the station holds RsLength+1 entries (8 by default).
- Widths come from the codebase defines, all with MSB-index convention: OP = `OpcodeLength+1 bits, DATA = `DataLength+1 bits (32), TAG = `PcLength+1 bits.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- is_empty_from_rob  in  1  1 = no instruction offered this cycle.
- is_sl_from_rob  in  1  1 = offered instruction is a load/store; it is not for this block and is ignored.
- is_exception_from_rob  in  1  flush request (mispredict or exception).
- is_commit_from_rob  in  1  result broadcast valid.
- op_from_rob  in  OP  opcode of the dispatched instruction.
- v1_from_rob, v2_from_rob  in  DATA  operand values; meaningful only when the matching tag is 0.
- q1_from_rob, q2_from_rob  in  TAG  producer tags; 0 = operand already valid.
- imm_from_rob  in  DATA  immediate.
- pc_from_rob  in  DATA  instruction pc.
- commit_data_from_rob  in  DATA  broadcast result value.
- commit_pc_from_rob  in  TAG  tag of the broadcast result.
- op_to_alu  out  OP  issued opcode; 0 = no issue (NOP).
- v1_to_alu, v2_to_alu, imm_to_alu, pc_to_alu  out  DATA  issued operands, immediate and pc.
- is_stall_to_instr_queue  out  1  station full.
- is_stall_to_rob  out  1  station full; identical to is_stall_to_instr_queue.

## Operation
- Entry state: valid, op, v1, v2, q1, q2, imm, pc. An entry is ready when valid, q1==0 and q2==0.
- Dispatch:
  - Occurs when is_empty_from_rob=0 and is_sl_from_rob=0 and the station is not full.
  - Writes the lowest-index free entry.
  - Dispatch while full is dropped; this is a protocol violation, because the ROB must honour the stall.
- Wakeup:
  - When is_commit_from_rob=1, every valid entry with q1==commit_pc_from_rob gets v1<=commit_data_from_rob and q1<=0. Same for q2/v2.
  - The instruction being dispatched in the same cycle is compared too; on a match it is stored with that data and its tag cleared.
  - Tag 0 never matches.
- Issue:
  - Selection uses the pre-edge entry state. The lowest-index ready entry is issued.
  - Its fields are registered onto the *_to_alu outputs and the entry is freed.
  - If no entry is ready, op_to_alu<=0; the data outputs hold their previous values.
  - At most one issue per cycle.
- Stall: is_stall_to_* = combinational (count of valid entries == RsLength+1).
- Flush:
  - is_exception_from_rob=1 invalidates all entries and forces op_to_alu<=0.
  - It overrides any dispatch, wakeup and issue in the same cycle.
- Priority per edge: rst > exception > (issue, wakeup, dispatch) applied concurrently. The issuing entry's slot is free for a dispatch only from the next cycle.

## Timing
- Reset: all entries invalid; op_to_alu, v1/v2/imm/pc_to_alu = 0; both stalls 0. Reset asserted mid-operation discards all contents the same edge.
- Ready-at-dispatch latency: dispatch sampled at edge N appears on op_to_alu after edge N+1.
- Wakeup latency: commit sampled at edge N makes the waiting entry eligible for issue at edge N+1, so its output is valid after N+1.
- Each output holds for exactly one cycle per issue; it returns to op 0 the next cycle unless another entry issues.
- Stall rises in the cycle after the dispatch that fills the last entry. It falls in the cycle after an issue frees one.
- Simultaneous issue and dispatch while holding RsLength entries: the count is unchanged and stall stays low.

## Test plan
- Reset, idle: rst=1 for 2 cycles, then is_empty_from_rob=1 -> all outputs 0, stalls 0.
- Ready dispatch: op=5, v1=10, v2=20, q1=q2=0, imm=3, pc=0x100 -> after the next edge, op_to_alu=5, v1=10, v2=20, imm=3, pc=0x100. The cycle after that, op_to_alu=0.
- Wakeup:
  - Stimulus: dispatch op=7 with q1=0x40 and q2=0, then hold 3 cycles -> op_to_alu stays 0.
  - Then commit_pc=0x40, data=0xDEAD -> op_to_alu=7 with v1=0xDEAD one edge later.
  - Same-cycle commit and dispatch: the instruction is stored already woken.
- Full/stall:
  - Dispatch 8 instructions all waiting on tag 0x80 -> stall=1 after the 8th.
  - A 9th dispatch is ignored.
  - Commit tag 0x80 -> issues in index order on 8 consecutive cycles, and stall drops after the first issue.
- Flush: 3 waiting entries, then is_exception_from_rob=1 together with a dispatch -> all entries and the dispatch discarded; op_to_alu=0; a later commit of their tag produces no issue.
- Ignore load/store: is_sl_from_rob=1 with a ready op -> no issue; occupancy unchanged.

Source files
------------

// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - out-of-order issue buffer between the ROB and the ALU
//
// Holds up to RsLength+1 non-memory instructions until both source operands
// are valid, snooping ROB commit broadcasts for the missing values, and issues
// the lowest-index ready entry to the ALU each cycle.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   is_empty_from_rob        no instruction offered this cycle
//   is_sl_from_rob           offered instruction is a load/store (ignored here)
//   is_exception_from_rob    flush all entries and the pending issue
//   is_commit_from_rob       commit broadcast valid
//   op/v1/v2/q1/q2/imm/pc_from_rob  dispatched instruction fields
//   commit_data_from_rob     broadcast result value
//   commit_pc_from_rob       broadcast result tag
//   op/v1/v2/imm/pc_to_alu   registered issue fields; op 0 means no issue
//   is_stall_to_instr_queue  station full
//   is_stall_to_rob          station full

`ifndef OpcodeLength
`define OpcodeLength 6
`endif
`ifndef DataLength
`define DataLength 31
`endif
`ifndef PcLength
`define PcLength 31
`endif

module reservation_station #(
    parameter int RsLength = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 is_empty_from_rob,
    input  logic                 is_sl_from_rob,
    input  logic                 is_exception_from_rob,
    input  logic                 is_commit_from_rob,
    input  logic [`OpcodeLength:0] op_from_rob,
    input  logic [`DataLength:0] v1_from_rob,
    input  logic [`DataLength:0] v2_from_rob,
    input  logic [`PcLength:0]   q1_from_rob,
    input  logic [`PcLength:0]   q2_from_rob,
    input  logic [`DataLength:0] imm_from_rob,
    input  logic [`DataLength:0] pc_from_rob,
    input  logic [`DataLength:0] commit_data_from_rob,
    input  logic [`PcLength:0]   commit_pc_from_rob,
    output logic [`OpcodeLength:0] op_to_alu,
    output logic [`DataLength:0] v1_to_alu,
    output logic [`DataLength:0] v2_to_alu,
    output logic [`DataLength:0] imm_to_alu,
    output logic [`DataLength:0] pc_to_alu,
    output logic                 is_stall_to_instr_queue,
    output logic                 is_stall_to_rob
);

    localparam int OW = `OpcodeLength + 1;
    localparam int DW = `DataLength + 1;
    localparam int TW = `PcLength + 1;
    localparam int NE = RsLength + 1;
    localparam int IW = (NE > 1) ? $clog2(NE) : 1;
    localparam int CW = $clog2(NE + 1);

    logic [NE-1:0] valid_q, valid_d;
    logic [OW-1:0] op_q  [NE];
    logic [OW-1:0] op_d  [NE];
    logic [DW-1:0] v1_q  [NE];
    logic [DW-1:0] v1_d  [NE];
    logic [DW-1:0] v2_q  [NE];
    logic [DW-1:0] v2_d  [NE];
    logic [TW-1:0] q1_q  [NE];
    logic [TW-1:0] q1_d  [NE];
    logic [TW-1:0] q2_q  [NE];
    logic [TW-1:0] q2_d  [NE];
    logic [DW-1:0] imm_q [NE];
    logic [DW-1:0] imm_d [NE];
    logic [DW-1:0] pc_q  [NE];
    logic [DW-1:0] pc_d  [NE];

    logic [NE-1:0] ready;
    logic [CW-1:0] count;
    logic          full;
    logic [IW-1:0] free_idx;
    logic [IW-1:0] iss_idx;
    logic          iss_found;
    logic          dispatch_en;
    logic          disp_hit1;
    logic          disp_hit2;

    // Occupancy, lowest free slot and lowest ready slot, all from pre-edge state.
    // Loops run high to low so the lowest matching index is the last write.
    always_comb begin
        count     = '0;
        free_idx  = '0;
        iss_idx   = '0;
        iss_found = 1'b0;
        ready     = '0;
        for (int i = NE - 1; i >= 0; i--) begin
            ready[i] = valid_q[i] && (q1_q[i] == '0) && (q2_q[i] == '0);
            count    = count + {{(CW-1){1'b0}}, valid_q[i]};
            if (!valid_q[i]) begin
                free_idx = IW'(i);
            end
            if (ready[i]) begin
                iss_idx   = IW'(i);
                iss_found = 1'b1;
            end
        end
    end

    assign full                    = (count == CW'(NE));
    assign is_stall_to_instr_queue = full;
    assign is_stall_to_rob         = full;

    // A write into a full station is dropped; the ROB is expected to honour the stall.
    assign dispatch_en = !is_empty_from_rob && !is_sl_from_rob && !full;

    // The incoming instruction snoops the same broadcast; tag 0 means "already valid".
    assign disp_hit1 = is_commit_from_rob && (q1_from_rob != '0) &&
                       (q1_from_rob == commit_pc_from_rob);
    assign disp_hit2 = is_commit_from_rob && (q2_from_rob != '0) &&
                       (q2_from_rob == commit_pc_from_rob);

    always_comb begin
        valid_d = valid_q;
        op_d    = op_q;
        v1_d    = v1_q;
        v2_d    = v2_q;
        q1_d    = q1_q;
        q2_d    = q2_q;
        imm_d   = imm_q;
        pc_d    = pc_q;
        for (int i = 0; i < NE; i++) begin
            if (valid_q[i] && is_commit_from_rob) begin
                if ((q1_q[i] != '0) && (q1_q[i] == commit_pc_from_rob)) begin
                    v1_d[i] = commit_data_from_rob;
                    q1_d[i] = '0;
                end
                if ((q2_q[i] != '0) && (q2_q[i] == commit_pc_from_rob)) begin
                    v2_d[i] = commit_data_from_rob;
                    q2_d[i] = '0;
                end
            end
            if (iss_found && (iss_idx == IW'(i))) begin
                valid_d[i] = 1'b0;
            end
            // free_idx points at a slot that was invalid pre-edge, so it never
            // collides with the issuing slot.
            if (dispatch_en && (free_idx == IW'(i))) begin
                valid_d[i] = 1'b1;
                op_d[i]    = op_from_rob;
                v1_d[i]    = disp_hit1 ? commit_data_from_rob : v1_from_rob;
                v2_d[i]    = disp_hit2 ? commit_data_from_rob : v2_from_rob;
                q1_d[i]    = disp_hit1 ? '0 : q1_from_rob;
                q2_d[i]    = disp_hit2 ? '0 : q2_from_rob;
                imm_d[i]   = imm_from_rob;
                pc_d[i]    = pc_from_rob;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            op_to_alu  <= '0;
            v1_to_alu  <= '0;
            v2_to_alu  <= '0;
            imm_to_alu <= '0;
            pc_to_alu  <= '0;
        end else if (is_exception_from_rob) begin
            valid_q   <= '0;
            op_to_alu <= '0;
        end else begin
            valid_q <= valid_d;
            if (iss_found) begin
                op_to_alu  <= op_q[iss_idx];
                v1_to_alu  <= v1_q[iss_idx];
                v2_to_alu  <= v2_q[iss_idx];
                imm_to_alu <= imm_q[iss_idx];
                pc_to_alu  <= pc_q[iss_idx];
            end else begin
                op_to_alu <= '0;
            end
        end
    end

    // Payload is only meaningful under valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        op_q  <= op_d;
        v1_q  <= v1_d;
        v2_q  <= v2_d;
        q1_q  <= q1_d;
        q2_q  <= q2_d;
        imm_q <= imm_d;
        pc_q  <= pc_d;
    end

endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - self-checking bench for reservation_station

`ifndef OpcodeLength
`define OpcodeLength 6
`endif
`ifndef DataLength
`define DataLength 31
`endif
`ifndef PcLength
`define PcLength 31
`endif

module tb_reservation_station;

    logic                   clk;
    logic                   rst;
    logic                   is_empty_from_rob;
    logic                   is_sl_from_rob;
    logic                   is_exception_from_rob;
    logic                   is_commit_from_rob;
    logic [`OpcodeLength:0] op_from_rob;
    logic [`DataLength:0]   v1_from_rob;
    logic [`DataLength:0]   v2_from_rob;
    logic [`PcLength:0]     q1_from_rob;
    logic [`PcLength:0]     q2_from_rob;
    logic [`DataLength:0]   imm_from_rob;
    logic [`DataLength:0]   pc_from_rob;
    logic [`DataLength:0]   commit_data_from_rob;
    logic [`PcLength:0]     commit_pc_from_rob;
    logic [`OpcodeLength:0] op_to_alu;
    logic [`DataLength:0]   v1_to_alu;
    logic [`DataLength:0]   v2_to_alu;
    logic [`DataLength:0]   imm_to_alu;
    logic [`DataLength:0]   pc_to_alu;
    logic                   is_stall_to_instr_queue;
    logic                   is_stall_to_rob;

    int n_cmp;
    int n_fail;

    reservation_station dut (
        .clk                     (clk),
        .rst                     (rst),
        .is_empty_from_rob       (is_empty_from_rob),
        .is_sl_from_rob          (is_sl_from_rob),
        .is_exception_from_rob   (is_exception_from_rob),
        .is_commit_from_rob      (is_commit_from_rob),
        .op_from_rob             (op_from_rob),
        .v1_from_rob             (v1_from_rob),
        .v2_from_rob             (v2_from_rob),
        .q1_from_rob             (q1_from_rob),
        .q2_from_rob             (q2_from_rob),
        .imm_from_rob            (imm_from_rob),
        .pc_from_rob             (pc_from_rob),
        .commit_data_from_rob    (commit_data_from_rob),
        .commit_pc_from_rob      (commit_pc_from_rob),
        .op_to_alu               (op_to_alu),
        .v1_to_alu               (v1_to_alu),
        .v2_to_alu               (v2_to_alu),
        .imm_to_alu              (imm_to_alu),
        .pc_to_alu               (pc_to_alu),
        .is_stall_to_instr_queue (is_stall_to_instr_queue),
        .is_stall_to_rob         (is_stall_to_rob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        is_empty_from_rob     = 1'b1;
        is_sl_from_rob        = 1'b0;
        is_exception_from_rob = 1'b0;
        is_commit_from_rob    = 1'b0;
    endtask

    task automatic drive_disp(input int op, input int v1, input int v2, input int q1,
                              input int q2, input int imm, input int pc);
        is_empty_from_rob = 1'b0;
        op_from_rob       = op[`OpcodeLength:0];
        v1_from_rob       = v1;
        v2_from_rob       = v2;
        q1_from_rob       = q1;
        q2_from_rob       = q2;
        imm_from_rob      = imm;
        pc_from_rob       = pc;
    endtask

    task automatic drive_commit(input int tag, input int data);
        is_commit_from_rob   = 1'b1;
        commit_pc_from_rob   = tag;
        commit_data_from_rob = data;
    endtask

    task automatic flush();
        idle();
        is_exception_from_rob = 1'b1;
        cycle();
        idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        drive_disp(0, 0, 0, 0, 0, 0, 0);
        idle();
        drive_commit(0, 0);
        idle();
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        n_cmp++; if (op_to_alu !== 7'd0) begin n_fail++; $display("FAIL reset_op: got %0h want 0", op_to_alu); end
        n_cmp++; if (v1_to_alu !== 32'd0) begin n_fail++; $display("FAIL reset_v1: got %0h want 0", v1_to_alu); end
        n_cmp++; if (v2_to_alu !== 32'd0) begin n_fail++; $display("FAIL reset_v2: got %0h want 0", v2_to_alu); end
        n_cmp++; if (imm_to_alu !== 32'd0) begin n_fail++; $display("FAIL reset_imm: got %0h want 0", imm_to_alu); end
        n_cmp++; if (pc_to_alu !== 32'd0) begin n_fail++; $display("FAIL reset_pc: got %0h want 0", pc_to_alu); end
        n_cmp++; if (is_stall_to_instr_queue !== 1'b0) begin n_fail++; $display("FAIL reset_stall_iq: got %0b want 0", is_stall_to_instr_queue); end
        n_cmp++; if (is_stall_to_rob !== 1'b0) begin n_fail++; $display("FAIL reset_stall_rob: got %0b want 0", is_stall_to_rob); end
    endtask

    task automatic test_ready_dispatch();
        drive_disp(5, 10, 20, 0, 0, 3, 'h100);
        cycle();
        idle();
        n_cmp++; if (op_to_alu !== 7'd0) begin n_fail++; $display("FAIL rd_early_op: got %0h want 0", op_to_alu); end
        cycle();
        n_cmp++; if (op_to_alu !== 7'd5) begin n_fail++; $display("FAIL rd_op: got %0h want 5", op_to_alu); end
        n_cmp++; if (v1_to_alu !== 32'd10) begin n_fail++; $display("FAIL rd_v1: got %0h want a", v1_to_alu); end
        n_cmp++; if (v2_to_alu !== 32'd20) begin n_fail++; $display("FAIL rd_v2: got %0h want 14", v2_to_alu); end
        n_cmp++; if (imm_to_alu !== 32'd3) begin n_fail++; $display("FAIL rd_imm: got %0h want 3", imm_to_alu); end
        n_cmp++; if (pc_to_alu !== 32'h100) begin n_fail++; $display("FAIL rd_pc: got %0h want 100", pc_to_alu); end
        cycle();
        n_cmp++; if (op_to_alu !== 7'd0) begin n_fail++; $display("FAIL rd_nop_after: got %0h want 0", op_to_alu); end
        n_cmp++; if (v1_to_alu !== 32'd10) begin n_fail++; $display("FAIL rd_v1_hold: got %0h want a", v1_to_alu); end
    endtask

    task automatic test_wakeup();
        drive_disp(7, 0, 'h22, 'h40, 0, 1, 'h104);
        cycle();
        idle();
        for (int k = 0; k < 3; k++) begin
            cycle();
            n_cmp++; if (op_to_alu !== 7'd0) begin n_fail++; $display("FAIL wk_wait_%0d: got %0h want 0", k, op_to_alu); end
        end
        drive_commit('h40, 'hDEAD);
        cycle();
        idle();
        n_cmp++; if (op_to_alu !== 7'd0) begin n_fail++; $display("FAIL wk_commit_edge: got %0h want 0", op_to_alu); end
        cycle();
        n_cmp++; if (op_to_alu !== 7'd7) begin n_fail++; $display("FAIL wk_op: got %0h want 7", op_to_alu); end
        n_cmp++; if (v1_to_alu !== 32'hDEAD) begin n_fail++; $display("FAIL wk_v1: got %0h want dead", v1_to_alu); end
        n_cmp++; if (v2_to_alu !== 32'h22) begin n_fail++; $display("FAIL wk_v2: got %0h want 22", v2_to_alu); end
        cycle();
        n_cmp++; if (op_to_alu !== 7'd0) begin n_fail++; $display("FAIL wk_nop_after: got %0h want 0", op_to_alu); end

        // Same-cycle commit and dispatch on q2: stored already woken.
        drive_disp(9, 'h5, 0, 0, 'h41, 0, 'h108);
        drive_commit('h41, 'hBEEF);
        cycle();
        idle();
        cycle();
        n_cmp++; if (op_to_alu !== 7'd9) begin n_fail++; $display("FAIL wk_same_op: got %0h want 9", op_to_alu); end
        n_cmp++; if (v2_to_alu !== 32'hBEEF) begin n_fail++; $display("FAIL wk_same_v2: got %0h want beef", v2_to_alu); end

        // A broadcast of tag 0 must not overwrite an already-valid operand.
        drive_disp(11, 'h11, 'h12, 0, 0, 0, 'h10C);
        drive_commit(0, 'h99);
        cycle();
        idle();
        cycle();
        n_cmp++; if (op_to_alu !== 7'd11) begin n_fail++; $display("FAIL wk_tag0_op: got %0h want b", op_to_alu); end
        n_cmp++; if (v1_to_alu !== 32'h11) begin n_fail++; $display("FAIL wk_tag0_v1: got %0h want 11", v1_to_alu); end
        cycle();
    endtask

    task automatic test_full();
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) drive_disp(k + 1, 0, k, 'h80, 0, k, 'h200 + k);
            else            drive_disp(k + 1, k, 0, 0, 'h80, k, 'h200 + k);
            cycle();
            if (k == 6) begin
                n_cmp++; if (is_stall_to_rob !== 1'b0) begin n_fail++; $display("FAIL full_stall_at7: got %0b want 0", is_stall_to_rob); end
            end
        end
        idle();
        n_cmp++; if (is_stall_to_instr_queue !== 1'b1) begin n_fail++; $display("FAIL full_stall_iq: got %0b want 1", is_stall_to_instr_queue); end
        n_cmp++; if (is_stall_to_rob !== 1'b1) begin n_fail++; $display("FAIL full_stall_rob: got %0b want 1", is_stall_to_rob); end
        // A ready instruction offered while full must be dropped.
        drive_disp('h3F, 1, 2, 0, 0, 0, 'h300);
        cycle();
        idle();
        cycle();
        n_cmp++; if (op_to_alu !== 7'd0) begin n_fail++; $display("FAIL full_drop_op: got %0h want 0", op_to_alu); end
        n_cmp++; if (is_stall_to_rob !== 1'b1) begin n_fail++; $display("FAIL full_drop_stall: got %0b want 1", is_stall_to_rob); end
        drive_commit('h80, 'h55);
        cycle();
        idle();
        for (int k = 0; k < 8; k++) begin
            cycle();
            n_cmp++; if (op_to_alu !== 7'(k + 1)) begin n_fail++; $display("FAIL full_iss_op_%0d: got %0h want %0h", k, op_to_alu, k + 1); end
            n_cmp++; if (v1_to_alu !== ((k % 2 == 0) ? 32'h55 : 32'(k))) begin n_fail++; $display("FAIL full_iss_v1_%0d: got %0h", k, v1_to_alu); end
            n_cmp++; if (v2_to_alu !== ((k % 2 == 0) ? 32'(k) : 32'h55)) begin n_fail++; $display("FAIL full_iss_v2_%0d: got %0h", k, v2_to_alu); end
            n_cmp++; if (pc_to_alu !== 32'(32'h200 + k)) begin n_fail++; $display("FAIL full_iss_pc_%0d: got %0h", k, pc_to_alu); end
            if (k == 0) begin
                n_cmp++; if (is_stall_to_rob !== 1'b0) begin n_fail++; $display("FAIL full_stall_drop: got %0b want 0", is_stall_to_rob); end
            end
        end
        cycle();
        n_cmp++; if (op_to_alu !== 7'd0) begin n_fail++; $display("FAIL full_drained: got %0h want 0", op_to_alu); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            drive_disp('h40 + k, 0, 0, 'h90, 0, 0, 0);
            cycle();
        end
        drive_disp('h21, 1, 1, 0, 0, 0, 'h400);
        cycle();
        n_cmp++; if (is_stall_to_rob !== 1'b0) begin n_fail++; $display("FAIL b2b_stall7: got %0b want 0", is_stall_to_rob); end
        drive_disp('h22, 2, 2, 0, 0, 0, 'h404);
        cycle();
        idle();
        n_cmp++; if (op_to_alu !== 7'h21) begin n_fail++; $display("FAIL b2b_op1: got %0h want 21", op_to_alu); end
        n_cmp++; if (is_stall_to_rob !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_swap: got %0b want 0", is_stall_to_rob); end
        cycle();
        n_cmp++; if (op_to_alu !== 7'h22) begin n_fail++; $display("FAIL b2b_op2: got %0h want 22", op_to_alu); end
        n_cmp++; if (pc_to_alu !== 32'h404) begin n_fail++; $display("FAIL b2b_pc2: got %0h want 404", pc_to_alu); end
        flush();
    endtask

    task automatic test_flush();
        for (int k = 0; k < 3; k++) begin
            drive_disp('h50 + k, 0, 0, 'hA0, 0, 0, 0);
            cycle();
        end
        drive_disp('h31, 0, 0, 0, 0, 0, 0);
        cycle();
        // Without the flush, 0x31 would issue on this edge.
        drive_disp('h30, 0, 0, 0, 0, 0, 0);
        is_exception_from_rob = 1'b1;
        cycle();
        idle();
        n_cmp++; if (op_to_alu !== 7'd0) begin n_fail++; $display("FAIL fl_op: got %0h want 0", op_to_alu); end
        cycle();
        n_cmp++; if (op_to_alu !== 7'd0) begin n_fail++; $display("FAIL fl_disp_dropped: got %0h want 0", op_to_alu); end
        drive_commit('hA0, 'h77);
        cycle();
        idle();
        for (int k = 0; k < 2; k++) begin
            cycle();
            n_cmp++; if (op_to_alu !== 7'd0) begin n_fail++; $display("FAIL fl_no_issue_%0d: got %0h want 0", k, op_to_alu); end
        end
        // Stale tag 0x90 entries from the previous flush stay gone too.
        drive_commit('h90, 'h1);
        cycle();
        idle();
        cycle();
        n_cmp++; if (op_to_alu !== 7'd0) begin n_fail++; $display("FAIL fl_stale_90: got %0h want 0", op_to_alu); end
    endtask

    task automatic test_ignore_sl();
        for (int k = 0; k < 6; k++) begin
            drive_disp('h60 + k, 0, 0, 'hB0, 0, 0, 0);
            cycle();
        end
        drive_disp('h12, 1, 1, 0, 0, 0, 'h500);
        is_sl_from_rob = 1'b1;
        cycle();
        idle();
        cycle();
        n_cmp++; if (op_to_alu !== 7'd0) begin n_fail++; $display("FAIL sl_no_issue: got %0h want 0", op_to_alu); end
        drive_disp('h66, 0, 0, 'hB0, 0, 0, 0);
        cycle();
        idle();
        // Seven entries held: the load/store must not have taken the eighth slot.
        n_cmp++; if (is_stall_to_rob !== 1'b0) begin n_fail++; $display("FAIL sl_occupancy: got %0b want 0", is_stall_to_rob); end
        flush();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        idle();
        test_reset();
        test_ready_dispatch();
        test_wakeup();
        test_full();
        test_back_to_back();
        test_flush();
        test_ignore_sl();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
